// File: rtl/rtds_pkg.sv
// ---------------------------------------------------------------------------
// rtds_pkg
// Shared definitions for the RTDS frame receiver.
//   AXIS_W     : width of one AXI-Stream beat / frame word
//   CNT_W      : width of the frame and error counters
//   rx_state_t : receive FSM states
// ---------------------------------------------------------------------------
package rtds_pkg;

    localparam int AXIS_W = 32;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_DROP = 2'd2
    } rx_state_t;

endpackage

// File: rtl/rtds_watchdog.sv
// ---------------------------------------------------------------------------
// rtds_watchdog
// Link watchdog: counts user_clk cycles since the last committed frame and
// saturates at TIMEOUT. stale is high when no frame has ever been committed
// since reset, or once the count has reached TIMEOUT.
// Ports:
//   user_clk    : clock
//   sys_reset_n : asynchronous active-low reset
//   clr         : a frame is being committed this cycle; restart the count
//   stale       : link considered stale
// ---------------------------------------------------------------------------
module rtds_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic user_clk,
    input  logic sys_reset_n,
    input  logic clr,
    output logic stale
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;
    logic          armed;

    always_ff @(posedge user_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            cnt   <= '0;
            armed <= 1'b0;
        end else if (clr) begin
            cnt   <= '0;
            armed <= 1'b1;
        end else if (cnt != CW'(TIMEOUT)) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Until the first commit there is no live link to speak of, so stay stale.
    assign stale = ~armed | (cnt == CW'(TIMEOUT));

endmodule

// File: rtl/rtds_frame_rx.sv
// ---------------------------------------------------------------------------
// rtds_frame_rx
// AXI-Stream sink for RTDS frames coming out of the augmented Aurora core.
// Words of a frame are collected in a staging buffer; a frame of acceptable
// length is copied atomically to frame_data one cycle after its tlast beat.
// Over-long frames and frames of the wrong length are rejected and counted.
// Ports:
//   user_clk, sys_reset_n       : clock, asynchronous active-low reset
//   s_axis_tvalid/tdata/tlast   : incoming stream
//   s_axis_tready               : always 1 out of reset (no back-pressure)
//   frame_data, frame_len       : last committed frame, word i at [32i+31:32i]
//   frame_valid                 : one-cycle pulse when frame_data updates
//   frame_count                 : committed frames (wrapping)
//   err_count                   : rejected frames (saturating)
//   err_overflow, err_length    : sticky error flags
//   err_clear                   : clears sticky flags and err_count
//   link_stale                  : no frame committed for TIMEOUT cycles
// ---------------------------------------------------------------------------
module rtds_frame_rx
    import rtds_pkg::*;
#(
    parameter int MAX_WORDS = 8,
    parameter int EXP_WORDS = 2,
    parameter int TIMEOUT   = 1024
) (
    input  logic                             user_clk,
    input  logic                             sys_reset_n,
    input  logic                             s_axis_tvalid,
    input  logic [AXIS_W-1:0]                s_axis_tdata,
    input  logic                             s_axis_tlast,
    output logic                             s_axis_tready,
    output logic [AXIS_W*MAX_WORDS-1:0]      frame_data,
    output logic [$clog2(MAX_WORDS+1)-1:0]   frame_len,
    output logic                             frame_valid,
    output logic [CNT_W-1:0]                 frame_count,
    output logic [CNT_W-1:0]                 err_count,
    output logic                             err_overflow,
    output logic                             err_length,
    input  logic                             err_clear,
    output logic                             link_stale
);

    localparam int LEN_W = $clog2(MAX_WORDS + 1);

    rx_state_t         state, state_nxt;
    logic [LEN_W-1:0]  wr_idx, wr_idx_nxt, cur_len;
    logic [AXIS_W-1:0] stg [MAX_WORDS];
    logic              beat, stg_we, commit, len_err, ovf_set, drop_err, err_now;

    assign s_axis_tready = sys_reset_n;
    assign beat          = s_axis_tvalid & s_axis_tready;
    assign cur_len       = wr_idx + LEN_W'(1);
    assign err_now       = len_err | drop_err;

    // In S_IDLE wr_idx is always 0, so idle and receive share one branch.
    always_comb begin
        state_nxt  = state;
        wr_idx_nxt = wr_idx;
        stg_we     = 1'b0;
        commit     = 1'b0;
        len_err    = 1'b0;
        ovf_set    = 1'b0;
        drop_err   = 1'b0;
        if (beat) begin
            case (state)
                S_IDLE, S_RECV: begin
                    if (int'(wr_idx) == MAX_WORDS) begin
                        // Buffer already full: this word makes the frame too long.
                        ovf_set = 1'b1;
                        if (s_axis_tlast) begin
                            drop_err   = 1'b1;
                            state_nxt  = S_IDLE;
                            wr_idx_nxt = '0;
                        end else begin
                            state_nxt = S_DROP;
                        end
                    end else if (s_axis_tlast) begin
                        if (EXP_WORDS != 0 && int'(cur_len) != EXP_WORDS) begin
                            len_err = 1'b1;
                        end else begin
                            commit = 1'b1;
                        end
                        state_nxt  = S_IDLE;
                        wr_idx_nxt = '0;
                    end else begin
                        stg_we     = 1'b1;
                        wr_idx_nxt = cur_len;
                        state_nxt  = S_RECV;
                    end
                end
                S_DROP: begin
                    if (s_axis_tlast) begin
                        drop_err   = 1'b1;
                        state_nxt  = S_IDLE;
                        wr_idx_nxt = '0;
                    end
                end
                default: begin
                    state_nxt  = S_IDLE;
                    wr_idx_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge user_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state  <= S_IDLE;
            wr_idx <= '0;
            for (int i = 0; i < MAX_WORDS; i++) begin
                stg[i] <= '0;
            end
        end else begin
            state  <= state_nxt;
            wr_idx <= wr_idx_nxt;
            for (int i = 0; i < MAX_WORDS; i++) begin
                if (stg_we && int'(wr_idx) == i) begin
                    stg[i] <= s_axis_tdata;
                end
            end
        end
    end

    // The tlast word bypasses staging and goes straight into the output bank,
    // so a frame starting on the very next beat can reuse staging safely.
    always_ff @(posedge user_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            frame_data  <= '0;
            frame_len   <= '0;
            frame_valid <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_valid <= commit;
            if (commit) begin
                for (int i = 0; i < MAX_WORDS; i++) begin
                    frame_data[AXIS_W*i +: AXIS_W] <= (int'(wr_idx) == i) ? s_axis_tdata : stg[i];
                end
                frame_len   <= cur_len;
                frame_count <= frame_count + CNT_W'(1);
            end
        end
    end

    // A new error in the same cycle as err_clear survives the clear.
    always_ff @(posedge user_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            err_count    <= '0;
            err_overflow <= 1'b0;
            err_length   <= 1'b0;
        end else if (err_clear) begin
            err_count    <= err_now ? CNT_W'(1) : '0;
            err_overflow <= ovf_set;
            err_length   <= len_err;
        end else begin
            if (err_now && err_count != '1) begin
                err_count <= err_count + CNT_W'(1);
            end
            err_overflow <= err_overflow | ovf_set;
            err_length   <= err_length | len_err;
        end
    end

    rtds_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .user_clk    (user_clk),
        .sys_reset_n (sys_reset_n),
        .clr         (commit),
        .stale       (link_stale)
    );

endmodule

// File: tb/tb_rtds_frame_rx.sv
// ---------------------------------------------------------------------------
// tb_rtds_frame_rx
// Two receivers share one stimulus stream: instance a uses the defaults
// (EXP_WORDS=2, TIMEOUT=1024), instance b disables the length check and uses
// a short watchdog. A frame-level model predicts both every cycle.
// ---------------------------------------------------------------------------
module tb_rtds_frame_rx;

    localparam int MAXW = 8;
    localparam int EXP_B = 0;
    localparam int TMO_B = 64;

    logic        user_clk;
    logic        sys_reset_n;
    logic        s_axis_tvalid;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tlast;
    logic        err_clear;

    logic              tready_a, fv_a, eo_a, el_a, ls_a;
    logic [32*MAXW-1:0] fd_a;
    logic [3:0]        fl_a;
    logic [15:0]       fc_a, ec_a;
    logic              tready_b, fv_b, eo_b, el_b, ls_b;
    logic [32*MAXW-1:0] fd_b;
    logic [3:0]        fl_b;
    logic [15:0]       fc_b, ec_b;

    rtds_frame_rx dut_a (
        .user_clk      (user_clk),
        .sys_reset_n   (sys_reset_n),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (tready_a),
        .frame_data    (fd_a),
        .frame_len     (fl_a),
        .frame_valid   (fv_a),
        .frame_count   (fc_a),
        .err_count     (ec_a),
        .err_overflow  (eo_a),
        .err_length    (el_a),
        .err_clear     (err_clear),
        .link_stale    (ls_a)
    );

    rtds_frame_rx #(
        .MAX_WORDS (MAXW),
        .EXP_WORDS (EXP_B),
        .TIMEOUT   (TMO_B)
    ) dut_b (
        .user_clk      (user_clk),
        .sys_reset_n   (sys_reset_n),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (tready_b),
        .frame_data    (fd_b),
        .frame_len     (fl_b),
        .frame_valid   (fv_b),
        .frame_count   (fc_b),
        .err_count     (ec_b),
        .err_overflow  (eo_b),
        .err_length    (el_b),
        .err_clear     (err_clear),
        .link_stale    (ls_b)
    );

    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    int          exp_w [2] = '{2, EXP_B};
    int          tmo   [2] = '{1024, TMO_B};
    int          m_n   [2];          // words seen in current frame
    bit          m_over[2];          // current frame already too long
    logic [31:0] m_cur [2][MAXW];
    logic [31:0] m_bank[2][MAXW];
    int          m_len [2], m_fc[2], m_ec[2], m_since[2];
    bit          m_eo  [2], m_el[2], m_fv[2], m_armed[2];

    always @(posedge user_clk or negedge sys_reset_n) begin
        for (int m = 0; m < 2; m++) begin
            bit e, so, sl, cm;
            e = 0; so = 0; sl = 0; cm = 0;
            if (!sys_reset_n) begin
                m_n[m] = 0; m_over[m] = 0; m_len[m] = 0; m_fc[m] = 0; m_ec[m] = 0;
                m_since[m] = 0; m_eo[m] = 0; m_el[m] = 0; m_fv[m] = 0; m_armed[m] = 0;
                for (int i = 0; i < MAXW; i++) m_bank[m][i] = 0;
            end else begin
                if (s_axis_tvalid) begin
                    if (!m_over[m]) begin
                        if (m_n[m] == MAXW) begin
                            m_over[m] = 1; so = 1;
                        end else begin
                            m_cur[m][m_n[m]] = s_axis_tdata;
                        end
                    end
                    m_n[m]++;
                    if (s_axis_tlast) begin
                        if (m_over[m]) e = 1;
                        else if (exp_w[m] != 0 && m_n[m] != exp_w[m]) begin e = 1; sl = 1; end
                        else begin
                            cm = 1;
                            for (int i = 0; i < m_n[m]; i++) m_bank[m][i] = m_cur[m][i];
                            m_len[m] = m_n[m];
                        end
                        m_n[m] = 0; m_over[m] = 0;
                    end
                end
                if (err_clear) begin
                    m_ec[m] = e ? 1 : 0; m_eo[m] = so; m_el[m] = sl;
                end else begin
                    if (e && m_ec[m] < 65535) m_ec[m]++;
                    m_eo[m] = m_eo[m] | so; m_el[m] = m_el[m] | sl;
                end
                m_fv[m] = cm;
                if (cm) begin
                    m_fc[m] = (m_fc[m] + 1) % 65536; m_since[m] = 0; m_armed[m] = 1;
                end else if (m_since[m] < tmo[m]) begin
                    m_since[m]++;
                end
            end
        end
    end

    task automatic cmp(input int m, input logic [32*MAXW-1:0] fd, input logic [3:0] fl,
                       input logic fv, input logic [15:0] fc, input logic [15:0] ec,
                       input logic eo, input logic el, input logic ls, input logic rdy);
        string p;
        int nw;
        p = (m == 0) ? "a" : "b";
        chk({p, ".tready"},       32'(rdy), 32'(sys_reset_n));
        chk({p, ".frame_valid"},  32'(fv),  32'(m_fv[m]));
        chk({p, ".frame_len"},    32'(fl),  m_len[m]);
        chk({p, ".frame_count"},  32'(fc),  m_fc[m]);
        chk({p, ".err_count"},    32'(ec),  m_ec[m]);
        chk({p, ".err_overflow"}, 32'(eo),  32'(m_eo[m]));
        chk({p, ".err_length"},   32'(el),  32'(m_el[m]));
        chk({p, ".link_stale"},   32'(ls),  32'(!m_armed[m] || m_since[m] == tmo[m]));
        nw = (m_len[m] == 0) ? MAXW : m_len[m];
        for (int i = 0; i < nw; i++)
            chk($sformatf("%s.word%0d", p, i), fd[32*i +: 32], m_bank[m][i]);
    endtask

    always @(negedge user_clk) begin
        if (chk_en) begin
            cmp(0, fd_a, fl_a, fv_a, fc_a, ec_a, eo_a, el_a, ls_a, tready_a);
            cmp(1, fd_b, fl_b, fv_b, fc_b, ec_b, eo_b, el_b, ls_b, tready_b);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge user_clk);
    endtask

    task automatic beat(input logic [31:0] d, input logic l);
        s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tlast = l;
        tick();
    endtask

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL sim_timeout: got no finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        sys_reset_n = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0;
        s_axis_tlast = 1'b0; err_clear = 1'b0;
        repeat (3) tick();
        #2 sys_reset_n = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        chk("lit.stale_reset", 32'(ls_a), 32'd1);
        chk("lit.count_reset", 32'(fc_a), 32'd0);

        // Basic two-word frame
        beat(32'h5, 1'b0);
        beat(32'h3, 1'b1);
        chk("lit.t1_valid", 32'(fv_a), 32'd1);
        chk("lit.t1_w0",    fd_a[31:0], 32'h5);
        chk("lit.t1_w1",    fd_a[63:32], 32'h3);
        chk("lit.t1_len",   32'(fl_a), 32'd2);
        chk("lit.t1_count", 32'(fc_a), 32'd1);
        chk("lit.t1_stale", 32'(ls_a), 32'd0);
        idle(2);

        // Wrong length for a, fine for b
        beat(32'h1, 1'b0);
        beat(32'h2, 1'b0);
        beat(32'h3, 1'b1);
        chk("lit.t2_valid", 32'(fv_a), 32'd0);
        chk("lit.t2_elen",  32'(el_a), 32'd1);
        chk("lit.t2_ecnt",  32'(ec_a), 32'd1);
        chk("lit.t2_w0",    fd_a[31:0], 32'h5);
        chk("lit.t2_b_len", 32'(fl_b), 32'd3);
        idle(2);

        // Ten-word frame overflows an 8-word bank at the ninth beat
        for (int i = 1; i <= 8; i++) beat(32'h100 + i, 1'b0);
        chk("lit.t3_no_ovf", 32'(eo_b), 32'd0);
        beat(32'h109, 1'b0);
        chk("lit.t3_ovf",   32'(eo_b), 32'd1);
        beat(32'h10A, 1'b1);
        chk("lit.t3_valid", 32'(fv_b), 32'd0);
        chk("lit.t3_b_ecnt", 32'(ec_b), 32'd1);
        chk("lit.t3_a_ecnt", 32'(ec_a), 32'd2);
        idle(1);
        beat(32'hAA, 1'b0);
        beat(32'hBB, 1'b1);
        chk("lit.t3_recover", 32'(fv_a), 32'd1);
        chk("lit.t3_w0",      fd_a[31:0], 32'hAA);
        chk("lit.t3_count",   32'(fc_a), 32'd2);

        // Back-to-back frames, gaps inside the second
        beat(32'h11, 1'b0);
        beat(32'h22, 1'b1);
        beat(32'h33, 1'b0);
        idle(2);
        beat(32'h44, 1'b1);
        chk("lit.t4_count", 32'(fc_a), 32'd4);
        chk("lit.t4_w0",    fd_a[31:0], 32'h33);
        chk("lit.t4_w1",    fd_a[63:32], 32'h44);

        // Plain clear
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("lit.clr_ovf",  32'(eo_a), 32'd0);
        chk("lit.clr_len",  32'(el_a), 32'd0);
        chk("lit.clr_ecnt", 32'(ec_a), 32'd0);

        // Watchdog
        beat(32'h7, 1'b0);
        beat(32'h8, 1'b1);
        chk("lit.wd_commit", 32'(fv_a), 32'd1);
        idle(1023);
        chk("lit.wd_1023", 32'(ls_a), 32'd0);
        idle(1);
        chk("lit.wd_1024", 32'(ls_a), 32'd1);
        beat(32'h9, 1'b0);
        beat(32'hA, 1'b1);
        chk("lit.wd_clear", 32'(ls_a), 32'd0);
        idle(2);

        // Randomised traffic
        for (int f = 0; f < 150; f++) begin
            int len;
            len = ($urandom_range(0, 2) == 0) ? 2 : int'($urandom_range(1, 10));
            for (int w = 0; w < len; w++) begin
                if ($urandom_range(0, 3) == 0) begin
                    s_axis_tvalid = 1'b0;
                    err_clear = ($urandom_range(0, 15) == 0);
                    tick();
                end
                err_clear = ($urandom_range(0, 15) == 0);
                beat($urandom, (w == len - 1));
            end
            err_clear = 1'b0;
            idle($urandom_range(0, 2));
        end

        // Reset in the middle of a frame
        beat(32'h55, 1'b0);
        beat(32'h66, 1'b0);
        s_axis_tvalid = 1'b0;
        #2 sys_reset_n = 1'b0;
        tick();
        chk("lit.rst_count", 32'(fc_a), 32'd0);
        chk("lit.rst_ecnt",  32'(ec_a), 32'd0);
        chk("lit.rst_w0",    fd_a[31:0], 32'd0);
        chk("lit.rst_len",   32'(fl_a), 32'd0);
        chk("lit.rst_stale", 32'(ls_a), 32'd1);
        tick();
        #2 sys_reset_n = 1'b1;
        tick();

        // Error, then clear coinciding with a new error
        beat(32'h1, 1'b1);
        chk("lit.ec_first", 32'(ec_a), 32'd1);
        beat(32'h1, 1'b0);
        beat(32'h2, 1'b0);
        err_clear = 1'b1;
        beat(32'h3, 1'b1);
        err_clear = 1'b0;
        chk("lit.ec_clr_flag", 32'(el_a), 32'd1);
        chk("lit.ec_clr_cnt",  32'(ec_a), 32'd1);
        idle(3);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/rtds_frame_rx.md
Name: rtds_frame_rx

Overview:
- AXI-Stream sink that sits directly downstream of the augmented-Aurora master interface (m_axis_*).
- Assembles each RTDS frame (32-bit words, frame terminated by tlast) into a staging buffer. On a good frame it commits the buffer atomically to a parallel output bank.
- Flags length/overflow errors and keeps frame and error counters.
- Runs a watchdog that reports a stale link when frames stop arriving.

Parameters:
- MAX_WORDS, 8, staging/output bank depth in 32-bit words (2..64).
- EXP_WORDS, 2, expected frame length; 0 disables the length check.
- TIMEOUT, 1024, user_clk cycles without a committed frame before link_stale asserts (>=2).

Ports:
- user_clk  in  1  Aurora user clock; single clock domain.
- sys_reset_n  in  1  reset, asynchronous, active-low.
- s_axis_tvalid  in  1  word valid.
- s_axis_tdata  in  32  frame word.
- s_axis_tlast  in  1  last word of frame.
- s_axis_tready  out  1  sink ready.
- frame_data  out  32*MAX_WORDS  committed frame; word i at bits [32*i+31:32*i].
- frame_len  out  $clog2(MAX_WORDS+1)  word count of committed frame.
- frame_valid  out  1  one-cycle pulse on commit.
- frame_count  out  16  committed frames, wraps 0xFFFF->0.
- err_count  out  16  rejected frames, saturates at 0xFFFF.
- err_overflow  out  1  sticky: frame exceeded MAX_WORDS.
- err_length  out  1  sticky: frame length != EXP_WORDS.
- err_clear  in  1  sync pulse; clears both sticky flags and err_count.
- link_stale  out  1  watchdog expired.

Behaviour:
- Reset (async assert, sync release): all outputs 0, except link_stale=1 (no frame yet). Staging buffer and FSM go to S_IDLE; watchdog counter is 0.
- s_axis_tready = 1 whenever out of reset; the block never back-pressures. A beat is accepted when tvalid & tready.
- FSM S_IDLE:
  - Beat with tlast=0 -> write word 0, wr_idx=1, go to S_RECV.
  - Beat with tlast=1 -> a single-word frame; evaluate immediately.
- FSM S_RECV:
  - Each beat writes the word at wr_idx and increments wr_idx.
  - Beat with tlast=1 -> evaluate, return to S_IDLE.
  - Beat with wr_idx==MAX_WORDS and tlast=0 -> set err_overflow, go to S_DROP.
- FSM S_DROP: discard beats; on a tlast beat, count one error (err_count+1) and return to S_IDLE. No commit.
- Evaluate, in the cycle after the tlast beat (len = words including the last):
  - If EXP_WORDS!=0 and len!=EXP_WORDS: set err_length, err_count+1, no commit.
  - Otherwise: copy staging to frame_data, set frame_len=len, pulse frame_valid for 1 cycle, frame_count+1, clear watchdog.
  - Latency is 1 cycle from the tlast beat to frame_valid and updated frame_data.
- frame_data holds the last good frame until the next commit. Rejected frames never alter frame_data or frame_len.
- A new frame may start in the beat right after tlast. The staging write and the commit copy must not collide: copy the words being committed (staging plus last word) in the same edge as the tlast beat, or double-buffer.
- Watchdog:
  - Counter increments every cycle and saturates at TIMEOUT.
  - link_stale = (counter==TIMEOUT).
  - A commit resets the counter to 0 and deasserts link_stale the same cycle frame_valid rises.
- err_clear coinciding with a new error: the error wins (flag stays set, err_count becomes 1).
- tvalid low mid-frame: FSM holds its state indefinitely; there is no inter-beat timeout.
- Reset mid-frame discards the partial frame. Counters and frame_data return to 0.

Decomposition:
- Package rtds_pkg: AXIS data width (32), FSM state encoding (S_IDLE, S_RECV, S_DROP), counter widths.
- One sub-module, rtds_watchdog: saturating counter with clear, stale output. Everything else stays inline.

Test Plan:
- {0x05, 0x03(tlast)} at defaults -> frame_valid 1 cycle after the tlast beat; frame_data[31:0]=5 and [63:32]=3; frame_len=2; frame_count=1; link_stale drops.
- 3-word frame {1,2,3(tlast)} with EXP_WORDS=2 -> no frame_valid, err_length=1, err_count=1, frame_data unchanged from prior frame.
- 10-word frame with MAX_WORDS=8, EXP_WORDS=0 -> err_overflow set at beat 9, no commit, err_count=1; next good 2-word frame commits normally.
- Back-to-back frames with no idle cycle, tvalid gaps inside the second frame -> both commit, frame_count=2, second frame data correct.
- No traffic for 1024 cycles after a good frame -> link_stale=1 exactly at cycle 1024; the next frame clears it.
- Assert sys_reset_n low mid-frame, then err_clear together with a new error -> all outputs reset; the error flag stays set and err_count=1.
